// File: rtl/btc_pkg.sv
// ---------------------------------------------------------------------------
// btc_pkg
// Shared definitions for the block-header nonce scanner:
//   - header / nonce / digest widths
//   - scanner FSM state encoding
//   - byte-swap helpers (Bitcoin mixes little-endian fields with
//     big-endian hashing, so both 32-bit and 256-bit swaps are needed)
//   - genesis-block constants, handy as a known-answer vector in benches
// ---------------------------------------------------------------------------
package btc_pkg;

  localparam int HDR_W    = 640;
  localparam int NONCE_W  = 32;
  localparam int HASH_W   = 256;
  localparam int PREFIX_W = HDR_W - NONCE_W;  // 76 header bytes before the nonce

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_HASH,
    S_CHECK
  } scan_state_t;

  function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] x);
    logic [NONCE_W-1:0] y;
    for (int i = 0; i < NONCE_W / 8; i++) begin
      y[8*i +: 8] = x[NONCE_W-8-8*i +: 8];
    end
    return y;
  endfunction

  function automatic logic [HASH_W-1:0] bswap256(input logic [HASH_W-1:0] x);
    logic [HASH_W-1:0] y;
    for (int i = 0; i < HASH_W / 8; i++) begin
      y[8*i +: 8] = x[HASH_W-8-8*i +: 8];
    end
    return y;
  endfunction

  // Genesis block: version, prev-hash, merkle root, time, bits (wire order).
  localparam logic [PREFIX_W-1:0] GENESIS_PREFIX = {
    32'h01000000,
    256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49,
    32'hffff001d
  };
  localparam logic [NONCE_W-1:0] GENESIS_NONCE  = 32'h7C2BAC1D;
  localparam logic [HASH_W-1:0]  GENESIS_TARGET = {32'h0, 32'hFFFF0000, 192'h0};
  localparam logic [HASH_W-1:0]  GENESIS_HASH   =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

endpackage

// File: rtl/hash_target_cmp.sv
// ---------------------------------------------------------------------------
// hash_target_cmp
// Purely combinational: converts the core digest (byte 0 at MSB) into its
// numeric value and compares it against the difficulty target.
// Kept as its own block so a pipeline stage can be added later without
// touching the scanner FSM.
// Ports:
//   core_hash_i  digest as produced by the core
//   target_i     numeric target
//   hash_num_o   byte-reversed (numeric) digest
//   hit_o        1 when hash_num_o <= target_i (unsigned)
// ---------------------------------------------------------------------------
module hash_target_cmp
  import btc_pkg::*;
(
  input  logic [HASH_W-1:0] core_hash_i,
  input  logic [HASH_W-1:0] target_i,
  output logic [HASH_W-1:0] hash_num_o,
  output logic              hit_o
);

  assign hash_num_o = bswap256(core_hash_i);
  assign hit_o      = (hash_num_o <= target_i);

endmodule

// File: rtl/nonce_scanner.sv
// ---------------------------------------------------------------------------
// nonce_scanner
// Upstream controller for the sha256 header-hash core. Walks a nonce range,
// restarting the core for each nonce, and stops on the first digest that
// meets the target or when the range is used up.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start             one-cycle pulse, begins a scan (ignored while busy or
//                     when abort is high in the same cycle)
//   abort             level, ends the scan at the next state boundary
//   header_in         header bytes 0..75, byte 0 at MSB   (sampled on start)
//   nonce_start/end   inclusive nonce range, may wrap     (sampled on start)
//   target            numeric target                      (sampled on start)
//   core_block        640-bit header to the core, nonce little-endian
//   core_rst_n        core restart, active low; low while idle and in LOAD
//   core_hash/done    digest and completion level from the core
//   busy              scan in progress
//   found/exhausted   outcome of the last scan, held until the next start
//   found_nonce/hash  nonce and numeric digest of the hit
//
// Optional: define NONCE_SCANNER_HASHCOUNT_EN to add a 64-bit saturating
// hash_count output counting every checked digest (not cleared by start).
// ---------------------------------------------------------------------------
module nonce_scanner
  import btc_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [PREFIX_W-1:0] header_in,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  input  logic [HASH_W-1:0]   target,
  output logic [HDR_W-1:0]    core_block,
  output logic                core_rst_n,
  input  logic [HASH_W-1:0]   core_hash,
  input  logic                core_done,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [HASH_W-1:0]   found_hash
`ifdef NONCE_SCANNER_HASHCOUNT_EN
  ,
  output logic [63:0]         hash_count
`endif
);

  scan_state_t         state_q, state_d;
  logic [PREFIX_W-1:0] hdr_q;
  logic [NONCE_W-1:0]  nonce_q, nonce_end_q, found_nonce_q;
  logic [HASH_W-1:0]   target_q, found_hash_q;
  logic                found_q, exhausted_q;
  logic                hash_seen_q;  // previous cycle was already HASH
  logic [HASH_W-1:0]   hash_num;
  logic                hit;
  logic                start_ok;
  logic                last_nonce;

  hash_target_cmp u_cmp (
    .core_hash_i (core_hash),
    .target_i    (target_q),
    .hash_num_o  (hash_num),
    .hit_o       (hit)
  );

  assign start_ok   = start && !abort;
  assign last_nonce = (nonce_q == nonce_end_q);

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_ok) state_d = S_LOAD;
      S_LOAD:  state_d = abort ? S_IDLE : S_HASH;
      // core_done on the first HASH cycle is a stale level from before the
      // core saw its reset, so it only counts once hash_seen_q is set.
      S_HASH: begin
        if (abort)                           state_d = S_IDLE;
        else if (core_done && hash_seen_q)   state_d = S_CHECK;
      end
      S_CHECK: state_d = (hit || last_nonce || abort) ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hdr_q         <= '0;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      hash_seen_q   <= 1'b0;
    end else begin
      hash_seen_q <= (state_q == S_HASH);
      if (state_q == S_IDLE && start_ok) begin
        hdr_q       <= header_in;
        nonce_q     <= nonce_start;
        nonce_end_q <= nonce_end;
        target_q    <= target;
        found_q     <= 1'b0;
        exhausted_q <= 1'b0;
      end
      if (state_q == S_CHECK) begin
        if (hit) begin
          found_q       <= 1'b1;
          found_nonce_q <= nonce_q;
          found_hash_q  <= hash_num;
        end else if (last_nonce) begin
          exhausted_q <= 1'b1;
        end else if (!abort) begin
          nonce_q <= nonce_q + 1'b1;  // wraps through zero
        end
      end
    end
  end

`ifdef NONCE_SCANNER_HASHCOUNT_EN
  logic [63:0] hash_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hash_count_q <= '0;
    end else if (state_q == S_CHECK && hash_count_q != '1) begin
      hash_count_q <= hash_count_q + 64'd1;
    end
  end

  assign hash_count = hash_count_q;
`endif

  // Outputs. The core stays out of reset through CHECK so its digest is
  // still valid while it is being compared.
  always_comb begin
    busy        = (state_q != S_IDLE);
    core_rst_n  = (state_q == S_HASH) || (state_q == S_CHECK);
    core_block  = {hdr_q, bswap32(nonce_q)};
    found       = found_q;
    exhausted   = exhausted_q;
    found_nonce = found_nonce_q;
    found_hash  = found_hash_q;
  end

endmodule
